// File: rtl/spi_master.sv
// SPI master that shifts out {data_in, key_in}, idles TURN SCLK periods, then reads a 128-bit reply.
// Optional abort input is enabled by defining SPI_MASTER_ABORT_EN.
module spi_master #(
  parameter int unsigned Nk      = 4,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned TURN    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [127:0]      data_in,
  input  logic [32*Nk-1:0]  key_in,
`ifdef SPI_MASTER_ABORT_EN
  input  logic              abort,
`endif
  output logic [127:0]      data_out,
  output logic              busy,
  output logic              done,
  output logic              SCLK,
  output logic              CS,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int unsigned TxBits = 128 + 32 * Nk;
  localparam int unsigned RxBits = 128;
  localparam int unsigned CntW   = 9;
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StSend = 3'd1;
  localparam logic [2:0] StTurn = 3'd2;
  localparam logic [2:0] StRecv = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic              sclk_q, sclk_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TxBits-1:0] tx_q, tx_d;
  logic [RxBits-1:0] rx_q, rx_d;
  logic [127:0]      dout_q, dout_d;

  logic abort_req;
  logic half_end;
  logic sclk_rise;
  logic sclk_fall;
  logic in_frame;
  logic accept;

`ifdef SPI_MASTER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign half_end  = (div_q == DivW'(CLK_DIV - 1));
  assign sclk_rise = half_end & ~sclk_q;
  assign sclk_fall = half_end & sclk_q;
  assign in_frame  = (state_q == StSend) | (state_q == StTurn) | (state_q == StRecv);
  // abort wins over a simultaneous start
  assign accept    = (state_q == StIdle) & start & ~abort_req;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sclk_d  = sclk_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;

    if (in_frame) begin
      div_d = half_end ? '0 : div_q + DivW'(1);
      if (half_end) begin
        sclk_d = ~sclk_q;
      end
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSend;
          tx_d    = {data_in, key_in};
          rx_d    = '0;
          cnt_d   = '0;
          div_d   = '0;
          sclk_d  = 1'b0;
        end
      end
      StSend: begin
        // the next bit appears on MOSI as SCLK falls, giving a full low phase of setup
        if (sclk_fall) begin
          tx_d = {tx_q[TxBits-2:0], 1'b0};
          if (cnt_q == CntW'(TxBits - 1)) begin
            state_d = StTurn;
            cnt_d   = '0;
            div_d   = '0;
            sclk_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StTurn: begin
        if (sclk_fall) begin
          if (cnt_q == CntW'(TURN - 1)) begin
            state_d = StRecv;
            cnt_d   = '0;
            div_d   = '0;
            sclk_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StRecv: begin
        if (sclk_rise) begin
          rx_d = {rx_q[RxBits-2:0], MISO};
        end
        // leave only after the falling edge so the last period is a full one
        if (sclk_fall) begin
          if (cnt_q == CntW'(RxBits - 1)) begin
            state_d = StDone;
            dout_d  = rx_q;
            cnt_d   = '0;
            div_d   = '0;
            sclk_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        div_d   = '0;
        sclk_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        div_d   = '0;
        sclk_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase

    if (abort_req && (state_q != StIdle)) begin
      state_d = StIdle;
      div_d   = '0;
      sclk_d  = 1'b0;
      cnt_d   = '0;
      dout_d  = dout_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      sclk_q  <= 1'b0;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
    end
  end

  assign data_out = dout_q;
  assign SCLK     = sclk_q;
  assign CS       = ~in_frame;
  assign MOSI     = (state_q == StSend) ? tx_q[TxBits-1] : 1'b0;
  assign done     = (state_q == StDone);
  // busy already covers the accepting cycle itself
  assign busy     = ~rst & ((state_q != StIdle) | accept);

endmodule

// File: tb/tb_spi_master.sv
// Randomized scoreboard bench for spi_master with a slave BFM on the serial pins.
// Under SPI_MASTER_ABORT_EN an abort-in-RECV scenario is added.
module tb_spi_master;

  localparam int unsigned NK   = 4;
  localparam int unsigned CDIV = 1;
  localparam int unsigned TRN  = 2;
  localparam int unsigned NB   = 128 + 32 * NK;
  localparam int unsigned PERIODS   = NB + TRN + 128;
  localparam int unsigned BUSY_CYC  = PERIODS * 2 * CDIV + 2;
  localparam int unsigned BOUND     = BUSY_CYC + 50;

  typedef struct {
    logic [127:0]  resp;
    logic [NB-1:0] tx;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [127:0]      data_in;
  logic [32*NK-1:0]  key_in;
  logic [127:0]      data_out;
  logic              busy, done, SCLK, CS, MOSI;
  logic              MISO = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
  logic              abort;
`endif

  spi_master #(.Nk(NK), .CLK_DIV(CDIV), .TURN(TRN)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .key_in   (key_in),
`ifdef SPI_MASTER_ABORT_EN
    .abort    (abort),
`endif
    .data_out (data_out),
    .busy     (busy),
    .done     (done),
    .SCLK     (SCLK),
    .CS       (CS),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int exp_done = 0;
  exp_t sb_q[$];

  logic [127:0]  cur_resp = '0;
  logic [NB-1:0] tx_cap = '0;
  int            rise_cnt = 0;
  logic [127:0]  model_dout = '0;

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting, want event within %0d cycles", name, BOUND);
  endtask

  function automatic logic [383:0] rnd384();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Slave BFM: count SCLK rises per CS frame, capture the command bits, serve the reply.
  always @(negedge CS or posedge SCLK) begin
    if (!SCLK) begin
      rise_cnt = 0;
      tx_cap   = '0;
    end else if (!CS) begin
      rise_cnt++;
      if (rise_cnt <= NB) tx_cap = {tx_cap[NB-2:0], MOSI};
    end
  end

  always @(negedge SCLK) begin : bfm_tx
    int k;
    if (!CS) begin
      k = rise_cnt - int'(NB) - int'(TRN);
      if (k >= 0 && k < 128) MISO = cur_resp[127-k];
    end
  end

  // Monitor: on each done pulse pop the expected frame and compare.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (busy) busy_cnt++;
    else busy_cnt = 0;
    if (done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_unexpected: got done pulse, want none");
      end else begin
        e = sb_q.pop_front();
        chk("data_out", 384'(data_out), 384'(e.resp));
        chk("mosi_stream", 384'(tx_cap), 384'(e.tx));
        chk("sclk_rises", 384'(rise_cnt), 384'(PERIODS));
        chk("busy_len", 384'(busy_cnt), 384'(BUSY_CYC));
      end
    end
  end

  task automatic launch(input logic [127:0] d, input logic [32*NK-1:0] k,
                        input logic [127:0] r, input bit push);
    logic [383:0] junk;
    @(posedge clk); #1;
    data_in  = d;
    key_in   = k;
    cur_resp = r;
    start    = 1'b1;
    if (push) begin
      sb_q.push_back('{r, {d, k}});
      exp_done++;
    end
    @(posedge clk); #1;
    start   = 1'b0;
    junk    = rnd384();
    data_in = junk[127:0];
    key_in  = junk[383 -: 32*NK];
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < int'(BOUND); c++) begin
      @(posedge clk); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_to(name);
  endtask

  task automatic wait_rises(input int n, input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < int'(BOUND); c++) begin
      @(negedge clk);
      if (rise_cnt >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_to(name);
  endtask

  initial begin
    logic [383:0] rv;
    logic [127:0] resp;
    bit seen;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    key_in  = '0;
`ifdef SPI_MASTER_ABORT_EN
    abort   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", 384'(CS), 384'(1));
    chk("rst_sclk", 384'(SCLK), 384'(0));
    chk("rst_mosi", 384'(MOSI), 384'(0));
    chk("rst_busy", 384'(busy), 384'(0));
    chk("rst_done", 384'(done), 384'(0));
    chk("rst_dout", 384'(data_out), 384'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Known vector: the slave replies with the AES-128 ciphertext of this block.
    launch(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
           128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);
    wait_idle("vec_frame");
    model_dout = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    for (int f = 0; f < 4; f++) begin
      rv   = rnd384();
      resp = rnd384()[127:0];
      repeat ($urandom_range(0, 6)) @(posedge clk);
      launch(rv[127:0], rv[383 -: 32*NK], resp, 1'b1);
      wait_idle("rand_frame");
      model_dout = resp;
    end

    // data_out must hold while inputs wander in idle
    repeat (5) begin
      @(posedge clk); #1;
      rv = rnd384();
      data_in = rv[127:0];
    end
    chk("hold_dout", 384'(data_out), 384'(model_dout));
    chk("idle_busy", 384'(busy), 384'(0));

    // start spammed during the frame and in the done cycle
    rv   = rnd384();
    resp = rnd384()[127:0];
    launch(rv[127:0], rv[383 -: 32*NK], resp, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < int'(BOUND); c++) begin
      @(posedge clk); #1;
      if (done) begin
        start = 1'b1;
        seen  = 1'b1;
        break;
      end
      start = ((c % 37) == 5);
    end
    if (!seen) fail_to("spam_done");
    @(posedge clk); #1;
    start = 1'b0;
    model_dout = resp;
    repeat (5) @(posedge clk);
    #1;
    chk("spam_no_restart_busy", 384'(busy), 384'(0));
    chk("spam_no_restart_cs", 384'(CS), 384'(1));

    // reset in the middle of SEND
    rv = rnd384();
    launch(rv[127:0], rv[383 -: 32*NK], rnd384()[127:0], 1'b0);
    wait_rises(50, "reach_bit50");
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_cs", 384'(CS), 384'(1));
    chk("midrst_busy", 384'(busy), 384'(0));
    chk("midrst_sclk", 384'(SCLK), 384'(0));
    chk("midrst_done", 384'(done), 384'(0));
    chk("midrst_dout", 384'(data_out), 384'(0));
    model_dout = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    rv   = rnd384();
    resp = rnd384()[127:0];
    launch(rv[127:0], rv[383 -: 32*NK], resp, 1'b1);
    wait_idle("post_rst_frame");
    model_dout = resp;

`ifdef SPI_MASTER_ABORT_EN
    rv = rnd384();
    launch(rv[127:0], rv[383 -: 32*NK], rnd384()[127:0], 1'b0);
    wait_rises(int'(NB + TRN) + 10, "reach_recv");
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_cs", 384'(CS), 384'(1));
    chk("abort_busy", 384'(busy), 384'(0));
    chk("abort_dout", 384'(data_out), 384'(model_dout));
`endif

    repeat (10) @(posedge clk);
    #1;
    chk("done_count", 384'(done_cnt), 384'(exp_done));
    chk("sb_empty", 384'(sb_q.size()), 384'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
